fifo_port_arbiter: RTL

Controller that shares one `syncbram_fifo` between several producers and drains it into a valid/ready consumer stream. The write side is a round-robin arbiter that drives the FIFO's `wr_en`/`buf_in` and never writes while `buf_full` is set. The read side is a small state machine that sequences the FIFO's `rd_en` and registered `buf_out` into a held `out_valid`/`out_data` pair. It sits directly around the FIFO instance: producers on one side, FIFO in the middle, consumer on the other.

---
 rtl/fifo_ctrl_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/fifo_port_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
// Shared constants for the FIFO port arbiter.
//   DEFAULT_DATA_W : default word width, which must match the shared FIFO
//   rd_state_t     : encoding type for the read-sequencing FSM
//   RS_IDLE        : waiting for the FIFO to become non-empty
//   RS_FETCH       : rd_en was sampled, so buf_out is valid this cycle
//   RS_HOLD        : out_data holds a word that has not been consumed yet
package fifo_ctrl_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef logic [1:0] rd_state_t;

  localparam logic [1:0] RS_IDLE  = 2'd0;
  localparam logic [1:0] RS_FETCH = 2'd1;
  localparam logic [1:0] RS_HOLD  = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick. The rotating pointer is owned by
// the parent module.
// Ports:
//   cand      in  NUM_REQ         : requests eligible this cycle
//   ptr       in  clog2(NUM_REQ)  : highest-priority index for this cycle
//   grant     out NUM_REQ         : one-hot grant, all zero if cand is empty
//   grant_idx out clog2(NUM_REQ)  : index of the granted bit, 0 if no grant
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         cand,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int   idx;
  logic found;

  // Walk NUM_REQ positions starting at ptr. The wrap is an explicit
  // subtraction, so NUM_REQ does not have to be a power of two.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && cand[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter
// Shares one syncbram_fifo among NUM_REQ producers and drains it into a
// valid/ready consumer stream.
// Ports:
//   clk, rst                      : clock and synchronous active-low reset
//   req_valid/req_data/req_ready  : producer side; req_ready is a one-hot grant
//   fifo_wr_en/fifo_buf_in        : FIFO write port
//   fifo_buf_full/fifo_buf_empty  : FIFO status flags
//   fifo_rd_en/fifo_buf_out       : FIFO read port; buf_out is valid one cycle after rd_en
//   out_valid/out_ready/out_data  : consumer side; out_data is registered
//   grant_id                      : index of the current grant, 0 if there is no grant
module fifo_port_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_buf_in,
  input  logic                        fifo_buf_full,
  input  logic                        fifo_buf_empty,
  output logic                        fifo_rd_en,
  input  logic [DATA_W-1:0]           fifo_buf_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // ---------------- write side ----------------
  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [DATA_W-1:0]  masked_data [NUM_REQ];

  // The full check is deliberately conservative. A pop in the same cycle
  // does not make room for a push.
  assign cand = (rst && !fifo_buf_full) ? req_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .cand      (cand),
    .ptr       (ptr_reg),
    .grant     (req_ready),
    .grant_idx (grant_id)
  );

  assign fifo_wr_en = |req_ready;

  // AND-OR data mux driven by the one-hot grant. The result is zero when
  // nobody is granted.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign masked_data[gi] = req_ready[gi] ? req_data[gi*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    fifo_buf_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fifo_buf_in = fifo_buf_in | masked_data[i];
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (fifo_wr_en) begin
      ptr_next = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
    end
  end

  // ---------------- read side ----------------
  rd_state_t         state_reg, state_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;

  assign fifo_rd_en = rst && !fifo_buf_empty &&
                      ((state_reg == RS_IDLE) || ((state_reg == RS_HOLD) && out_ready));

  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    case (state_reg)
      RS_IDLE: begin
        if (fifo_rd_en) state_next = RS_FETCH;
      end
      RS_FETCH: begin
        // buf_out is valid now because rd_en was sampled at the last edge.
        out_data_next  = fifo_buf_out;
        out_valid_next = 1'b1;
        state_next     = RS_HOLD;
      end
      RS_HOLD: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = fifo_rd_en ? RS_FETCH : RS_IDLE;
        end
      end
      default: begin
        out_valid_next = 1'b0;
        state_next     = RS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg       <= '0;
      state_reg     <= RS_IDLE;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule
